// File: rtl/pdfd_tap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pdfd_ctrl_pkg                                                 |
// | Description : Shared constants, state encoding and tap type for the LaPDFD  |
// |               tap controller.                                               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package pdfd_ctrl_pkg;

  localparam int N_LANES      = 4;
  localparam int N_TAPS       = 14;
  localparam int SAMPLE_W     = 8;
  localparam int TAP_W        = 8;
  localparam int SYM_W        = 3;
  localparam int FLUSH_CYCLES = 14;
  localparam int LATENCY      = 15;
  localparam int ADDR_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_t;

  typedef logic signed [TAP_W-1:0] tap_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdfd_tap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pdfd_tap_ctrl_if                                              |
// | Description : Tap configuration port (write, commit, error, readback when   |
// |               PDFD_CTRL_READBACK_EN is defined).                            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface pdfd_tap_ctrl_if #(
  parameter int TAP_W  = 8,
  parameter int ADDR_W = 4
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [TAP_W-1:0]  cfg_data;
  logic              cfg_commit;
  logic              cfg_err;
`ifdef PDFD_CTRL_READBACK_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [TAP_W-1:0]  rd_data;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit, rd_addr,
    input  cfg_ready, cfg_err, rd_data
  );
  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit, rd_addr,
    output cfg_ready, cfg_err, rd_data
  );
`else
  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready, cfg_err
  );
  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready, cfg_err
  );
`endif

endinterface
`default_nettype wire

// File: rtl/pdfd_tap_ctrl_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdfd_tap_bank                                                 |
// | Description : Shadow/active tap banks with write-through-commit forwarding  |
// |               and optional registered readback (PDFD_CTRL_READBACK_EN).     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module pdfd_tap_bank
  import pdfd_ctrl_pkg::*;
#(
  parameter int N_TAPS = pdfd_ctrl_pkg::N_TAPS,
  parameter int TAP_W  = pdfd_ctrl_pkg::TAP_W,
  parameter int ADDR_W = pdfd_ctrl_pkg::ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [TAP_W-1:0]        wr_data,
  input  logic                    commit,
`ifdef PDFD_CTRL_READBACK_EN
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [TAP_W-1:0]        rd_data,
`endif
  output logic [N_TAPS*TAP_W-1:0] taps
);

  logic [TAP_W-1:0] r_shadow [N_TAPS];
  logic [TAP_W-1:0] r_active [N_TAPS];
  logic             w_wr_hit;

  assign w_wr_hit = wr_en && (wr_addr < ADDR_W'(N_TAPS));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr_hit) begin
        r_shadow[wr_addr] <= wr_data;
      end
      // A write landing on the commit edge is forwarded into the active bank.
      if (commit) begin
        for (int i = 0; i < N_TAPS; i++) begin
          r_active[i] <= (w_wr_hit && (wr_addr == ADDR_W'(i))) ? wr_data : r_shadow[i];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_TAPS; g++) begin : g_pack
      assign taps[g*TAP_W +: TAP_W] = r_active[g];
    end
  endgenerate

`ifdef PDFD_CTRL_READBACK_EN
  logic [TAP_W-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (rd_addr < ADDR_W'(N_TAPS)) begin
      r_rd_data <= r_active[rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: rtl/pdfd_tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdfd_tap_ctrl                                                 |
// | Description : LaPDFD tap configuration and flush/warm-up sequencer.         |
// |               Optional readback port: PDFD_CTRL_READBACK_EN.               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module pdfd_tap_ctrl
  import pdfd_ctrl_pkg::*;
#(
  parameter int N_LANES      = pdfd_ctrl_pkg::N_LANES,
  parameter int N_TAPS       = pdfd_ctrl_pkg::N_TAPS,
  parameter int SAMPLE_W     = pdfd_ctrl_pkg::SAMPLE_W,
  parameter int TAP_W        = pdfd_ctrl_pkg::TAP_W,
  parameter int SYM_W        = pdfd_ctrl_pkg::SYM_W,
  parameter int FLUSH_CYCLES = pdfd_ctrl_pkg::FLUSH_CYCLES,
  parameter int LATENCY      = pdfd_ctrl_pkg::LATENCY
) (
  input  logic                        clock,
  input  logic                        reset,
  pdfd_tap_ctrl_if.slave              cfg,
  input  logic [N_LANES*SAMPLE_W-1:0] in_samples,
  output logic [N_LANES*SAMPLE_W-1:0] dec_samples,
  output logic [N_TAPS*TAP_W-1:0]     dec_taps,
  input  logic [N_LANES*SYM_W-1:0]    dec_rxData,
  input  logic                        dec_rxValid,
  output logic [N_LANES*SYM_W-1:0]    out_data,
  output logic                        out_valid,
  output logic                        busy
);

  localparam int CNT_W = $clog2(max2(FLUSH_CYCLES, LATENCY) + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_pass;

  // A commit overrides every state, including an in-progress flush or warm-up.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (cfg.cfg_commit) begin
      r_state <= FLUSH;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
            r_state <= WARMUP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WARMUP: begin
          if (r_cnt == CNT_W'(LATENCY - 1)) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (cfg.cfg_valid && (cfg.cfg_addr >= 4'(N_TAPS))) begin
      r_err <= 1'b1;
    end
  end

  assign cfg.cfg_ready = 1'b1;
  assign cfg.cfg_err   = r_err;

  pdfd_tap_bank #(
    .N_TAPS (N_TAPS),
    .TAP_W  (TAP_W),
    .ADDR_W (4)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (cfg.cfg_valid),
    .wr_addr (cfg.cfg_addr),
    .wr_data (cfg.cfg_data),
    .commit  (cfg.cfg_commit),
`ifdef PDFD_CTRL_READBACK_EN
    .rd_addr (cfg.rd_addr),
    .rd_data (cfg.rd_data),
`endif
    .taps    (dec_taps)
  );

  assign w_pass      = (r_state == WARMUP) || (r_state == RUN);
  assign dec_samples = w_pass ? in_samples : '0;
  assign out_valid   = (r_state == RUN) && dec_rxValid;
  assign busy        = (r_state == FLUSH) || (r_state == WARMUP);
  assign out_data    = dec_rxData;

endmodule
`default_nettype wire

// File: tb/tb_pdfd_tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pdfd_tap_ctrl                                              |
// | Description : Directed self-checking bench for pdfd_tap_ctrl.               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pdfd_tap_ctrl;

  logic         clock;
  logic         reset;
  logic [31:0]  in_samples;
  logic [31:0]  dec_samples;
  logic [111:0] dec_taps;
  logic [11:0]  dec_rxData;
  logic         dec_rxValid;
  logic [11:0]  out_data;
  logic         out_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_taps [14];

  pdfd_tap_ctrl_if #(.TAP_W(8), .ADDR_W(4)) cfg_if ();

  pdfd_tap_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cfg         (cfg_if),
    .in_samples  (in_samples),
    .dec_samples (dec_samples),
    .dec_taps    (dec_taps),
    .dec_rxData  (dec_rxData),
    .dec_rxValid (dec_rxValid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] pack_taps();
    logic [111:0] v;
    for (int i = 0; i < 14; i++) v[i*8 +: 8] = exp_taps[i];
    return v;
  endfunction

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_data  = data;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_commit = 1'b0;
  endtask

  // Called in the first FLUSH cycle; leaves the DUT in its first RUN cycle.
  task automatic check_seq();
    logic [31:0] samp;
    dec_rxValid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      samp = {4{8'(8'h80 + k)}};
      in_samples = samp;
      #1;
      check("flush_samples", dec_samples, 0);
      check("flush_valid", out_valid, 0);
      check("flush_busy", busy, 1);
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      samp = {4{8'(8'hF0 - k)}};
      in_samples = samp;
      #1;
      check("warm_samples", dec_samples, samp);
      check("warm_valid", out_valid, 0);
      check("warm_busy", busy, 1);
      tick();
    end
    samp = 32'h7F80_01FF;
    in_samples = samp;
    #1;
    check("run_samples", dec_samples, samp);
    check("run_valid_hi", out_valid, 1);
    check("run_busy", busy, 0);
    dec_rxValid = 1'b0;
    #1;
    check("run_valid_lo", out_valid, 0);
    dec_rxValid = 1'b1;
  endtask

  initial begin
    reset             = 1'b1;
    in_samples        = '0;
    dec_rxData        = '0;
    dec_rxValid       = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_addr   = '0;
    cfg_if.cfg_data   = '0;
    cfg_if.cfg_commit = 1'b0;
`ifdef PDFD_CTRL_READBACK_EN
    cfg_if.rd_addr    = '0;
`endif
    for (int i = 0; i < 14; i++) exp_taps[i] = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    in_samples  = {4{8'd101}};
    dec_rxValid = 1'b1;
    dec_rxData  = 12'hA5C;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle_samples", dec_samples, 0);
      check("idle_valid", out_valid, 0);
      check("idle_taps", dec_taps, 0);
      check("idle_busy", busy, 0);
    end
    check("cfg_ready", cfg_if.cfg_ready, 1);
    check("cfg_err_rst", cfg_if.cfg_err, 0);
    check("out_data", out_data, 12'hA5C);

    // 2: load taps 1..14 and commit
    for (int i = 0; i < 14; i++) begin
      wr(4'(i), 8'(i + 1));
      exp_taps[i] = 8'(i + 1);
    end
    check("shadow_only", dec_taps, 0);
    commit();
    check("commit_taps", dec_taps, pack_taps());
    check_seq();
    dec_rxData = 12'h3C1;
    #1;
    check("run_out_data", out_data, 12'h3C1);
`ifdef PDFD_CTRL_READBACK_EN
    cfg_if.rd_addr = 4'd5;
    tick();
    check("rd_tap5", cfg_if.rd_data, 8'd6);
    cfg_if.rd_addr = 4'd15;
    tick();
    check("rd_oor", cfg_if.rd_data, 0);
`endif

    // 3: write forwarded through a simultaneous commit
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_addr   = 4'd3;
    cfg_if.cfg_data   = 8'hCC;
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    exp_taps[3] = 8'hCC;
    check("fwd_taps", dec_taps, pack_taps());
    check_seq();

    // 4: commit at WARMUP count 7 restarts the flush
    commit();
    for (int k = 0; k < 21; k++) tick();
    check("mid_busy", busy, 1);
    check("mid_valid", out_valid, 0);
    check("mid_samples", dec_samples, in_samples);
    commit();
    check_seq();

    // 5: out-of-range write
    wr(4'd14, 8'h55);
    check("err_set", cfg_if.cfg_err, 1);
    for (int k = 0; k < 3; k++) tick();
    check("err_sticky", cfg_if.cfg_err, 1);
    check("err_taps", dec_taps, pack_taps());
    commit();
    check("err_commit_taps", dec_taps, pack_taps());
    check("err_after_commit", cfg_if.cfg_err, 1);
    check_seq();

    // 6: reset during RUN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dec_rxValid = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_taps", dec_taps, 0);
    check("rst_valid", out_valid, 0);
    check("rst_samples", dec_samples, 0);
    check("rst_err", cfg_if.cfg_err, 0);
`ifdef PDFD_CTRL_READBACK_EN
    for (int a = 0; a < 16; a++) begin
      cfg_if.rd_addr = 4'(a);
      tick();
      check("rst_rd", cfg_if.rd_data, 0);
    end
`endif
    tick();
    check("rst_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdfd_tap_ctrl.md
Name: pdfd_tap_ctrl

Overview:
Configuration and startup sequencer for the LaPDFD parallel decision-feedback decoder.
- Collects 14 signed feedback taps through a valid/ready write port into a shadow bank.
- Applies the taps to the decoder atomically on a commit.
- Flushes the decoder pipeline with zero samples, then masks the decoder's rxValid until the pipeline latency has elapsed.
- Sits between the receive front end / config bus and the LaPDFD instance.

Parameters:
N_LANES, 4, samples per cycle (decoder parallelism)
N_TAPS, 14, number of feedback taps
SAMPLE_W, 8, signed sample width
TAP_W, 8, signed tap width
SYM_W, 3, bits per decoded symbol
FLUSH_CYCLES, 14, cycles of forced-zero samples after a commit
LATENCY, 15, decoder pipeline depth in cycles; rxValid is masked for this many cycles after the flush

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
cfg_valid  in  1  tap write request
cfg_ready  out  1  tap write accept
cfg_addr  in  4  tap index 0..N_TAPS-1
cfg_data  in  TAP_W  signed tap value
cfg_commit  in  1  single-cycle pulse: apply shadow taps and restart the sequence
cfg_err  out  1  sticky flag: write to an out-of-range address
in_samples  in  N_LANES*SAMPLE_W  front-end samples; lane i at [i*SAMPLE_W +: SAMPLE_W]
dec_samples  out  N_LANES*SAMPLE_W  samples to the decoder (io_rxSamples_*)
dec_taps  out  N_TAPS*TAP_W  active taps to the decoder (io_taps_*); tap i at [i*TAP_W +: TAP_W]
dec_rxData  in  N_LANES*SYM_W  decoder symbols
dec_rxValid  in  1  decoder valid
out_data  out  N_LANES*SYM_W  qualified symbols
out_valid  out  1  qualified valid
busy  out  1  high in FLUSH or WARMUP

Behaviour:
- Reset values:
  - state = IDLE; shadow and active banks all 0; dec_taps = 0.
  - cfg_err = 0; out_valid = 0; busy = 0; cfg_ready = 1.
  - A reset asserted mid-sequence aborts the sequence immediately; the state after the reset edge is IDLE.
- States:
  - IDLE: dec_samples = 0; out_valid = 0.
  - FLUSH: dec_samples = 0; out_valid = 0.
  - WARMUP: dec_samples = in_samples; out_valid = 0.
  - RUN: dec_samples = in_samples; out_valid = dec_rxValid.
  - out_data = dec_rxData combinationally in every state; consumers qualify it with out_valid.
- Transitions:
  - Any state with cfg_commit at an edge -> FLUSH, counter = 0.
  - FLUSH -> WARMUP after exactly FLUSH_CYCLES cycles in FLUSH.
  - WARMUP -> RUN after exactly LATENCY cycles in WARMUP.
  - RUN remains in RUN until the next commit.
- Counter width: clog2(max(FLUSH_CYCLES, LATENCY) + 1). The counter resets to 0 on every state entry.
- A commit while in FLUSH or WARMUP restarts FLUSH from count 0. Active taps are reloaded.
- Write port:
  - cfg_ready is held at 1; a write is accepted when cfg_valid is high.
  - An accepted write updates shadow[cfg_addr] at the edge.
  - cfg_addr >= N_TAPS: the write is accepted and discarded, and cfg_err is set. cfg_err clears only on reset.
- Commit:
  - At the commit edge, active <= shadow; dec_taps changes in the cycle after the edge.
  - A write and a commit at the same edge: the written value is forwarded, so the active bank includes the write.
  - Shadow writes never disturb active taps.
- Paths:
  - dec_samples and out_valid are combinational from state, in_samples and dec_rxValid.
  - dec_taps is registered.
- Arithmetic: no arithmetic on samples or taps; signed values pass bit-exact.

Optional Feature:
PDFD_CTRL_READBACK_EN
- Defined: adds input rd_addr[3:0] and output rd_data[TAP_W-1:0].
  - rd_data is registered, with 1-cycle latency.
  - It returns active[rd_addr], or 0 when the address is out of range.
  - Reset value of rd_data is 0.
- Undefined: both ports and the register are absent; all other behaviour is identical.

Decomposition:
- Package pdfd_ctrl_pkg contains:
  - the state enum (IDLE, FLUSH, WARMUP, RUN);
  - default constants for N_LANES, N_TAPS, SAMPLE_W, TAP_W, SYM_W, FLUSH_CYCLES and LATENCY;
  - the tap_t signed typedef.
- One sub-module, pdfd_tap_bank:
  - holds the shadow and active banks;
  - implements write-plus-commit forwarding;
  - implements readback when enabled.
- The sequencer FSM lives in the top module.

Test Plan:
1. Reset, then drive in_samples = 101 on all lanes for 5 cycles -> dec_samples = 0, out_valid = 0, dec_taps = 0, busy = 0.
2. Write taps 0..13 with values 1..14, then pulse commit -> the cycle after the commit edge shows dec_taps[i] = i+1; dec_samples = 0 for 14 cycles; out_valid = 0 for a further 15 cycles with dec_samples = in_samples; RUN follows, with out_valid tracking dec_rxValid.
3. Write tap 3 = -52 in the same cycle as commit -> the active tap 3 is -52 in the cycle after the commit edge.
4. Pulse commit at WARMUP count 7 -> FLUSH restarts; 14 zero cycles plus 15 masked cycles occur before RUN.
5. Write cfg_addr = 14 with data 0x55 -> cfg_err = 1 and stays high; no tap changes; only reset clears cfg_err.
6. Assert reset for 1 cycle during RUN -> the state after the reset edge is IDLE, dec_taps = 0 and out_valid = 0; with readback enabled, rd_data = 0 for every address.
